// File: rtl/s1_pkg.sv
// Shared types for the memory stage: bus FSM states, stage register layout
// and write-back source encodings.
package s1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_LOAD = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic [2:0]  wb_lines;
        logic [29:0] pc;
        logic        req;
        logic        we;
    } stage_t;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Bus handshake controller: IDLE/BUSY/DONE FSM, BUSY-cycle timeout counter
// and the load buffer that keeps read data alive while the pipeline is frozen.
module mem_bus_ctrl
    import s1_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        async_rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        done,
    output logic        abort,
    output logic [31:0] load_data
);

    mem_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] lb_q, lb_d;
    logic        err_q, err_d;
    logic        busy;
    logic        ack_hit;
    logic        timeout;

    always_comb begin
        busy    = (state_q == BUSY);
        ack_hit = busy & bus_ack;
        timeout = busy & ~bus_ack & (cnt_q == 8'(TIMEOUT - 1));

        state_d = state_q;
        lb_d    = lb_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (start) state_d = BUSY;
            end
            BUSY: begin
                // A late ack on the final allowed cycle still wins over the abort.
                if (ack_hit) begin
                    lb_d    = bus_rdata;
                    err_d   = 1'b0;
                    state_d = clk_en ? IDLE : DONE;
                end else if (timeout) begin
                    lb_d    = '0;
                    err_d   = 1'b1;
                    state_d = clk_en ? IDLE : DONE;
                end
            end
            DONE: begin
                if (clk_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = (busy && state_d == BUSY) ? cnt_q + 8'd1 : 8'd0;

        bus_req   = busy;
        done      = ack_hit | (state_q == DONE) | timeout;
        abort     = timeout | ((state_q == DONE) & err_q);
        load_data = ack_hit ? bus_rdata : (timeout ? 32'd0 : lb_q);
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lb_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lb_q    <= lb_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: stage register, write-back source mux, result
// register and forwarding path; bus sequencing is delegated to mem_bus_ctrl.
module mem_stage
    import s1_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        async_rst,
    input  logic        clk_en,
    input  logic        valid_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] store_data,
    input  logic [31:0] inst_in,
    input  logic [29:0] pc_in,
    input  logic [2:0]  wb_lines_in,
    input  logic        mem_req_in,
    input  logic        mem_we_in,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_req,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic        valid_out,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        forward,
    output logic [4:0]  fwd_rd_addr,
    output logic [31:0] fwd_data
);

    stage_t      s_q, s_d;
    logic        done;
    logic        abort;
    logic [31:0] load_data;
    logic        fire;
    logic [29:0] link_pc;
    logic [31:0] res_data;

    logic        valid_out_q, valid_out_d;
    logic        wb_en_q, wb_en_d;
    logic        bus_err_q, bus_err_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;

    // Only the rd field of the instruction matters at this stage.
    logic unused_inst;
    assign unused_inst = ^{inst_in[31:12], inst_in[6:0]};

    mem_bus_ctrl #(.TIMEOUT(TIMEOUT)) u_bus_ctrl (
        .clk       (clk),
        .async_rst (async_rst),
        .clk_en    (clk_en),
        .start     (s_q.valid & s_q.req),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .bus_req   (bus_req),
        .done      (done),
        .abort     (abort),
        .load_data (load_data)
    );

    assign stall = s_q.valid & s_q.req & ~done;

    always_comb begin
        s_d = s_q;
        if (clk_en && !stall) begin
            s_d.valid    = valid_in;
            s_d.alu      = alu_in;
            s_d.sdata    = store_data;
            s_d.rd       = inst_in[11:7];
            s_d.wb_lines = wb_lines_in;
            s_d.pc       = pc_in;
            s_d.req      = mem_req_in;
            s_d.we       = mem_we_in;
        end
    end

    always_comb begin
        fire    = s_q.valid & ~stall;
        link_pc = s_q.pc + 30'd1;
        unique case (s_q.wb_lines[2:1])
            WB_SRC_LOAD: res_data = load_data;
            WB_SRC_LINK: res_data = {link_pc, 2'b00};
            default:     res_data = s_q.alu;
        endcase

        valid_out_d = valid_out_q;
        wb_en_d     = wb_en_q;
        bus_err_d   = bus_err_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        if (clk_en) begin
            valid_out_d = fire;
            wb_en_d     = fire & s_q.wb_lines[0] & (s_q.rd != 5'd0);
            bus_err_d   = fire & s_q.req & abort;
            wb_rd_d     = s_q.rd;
            wb_data_d   = res_data;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            s_q         <= '0;
            valid_out_q <= 1'b0;
            wb_en_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            s_q         <= s_d;
            valid_out_q <= valid_out_d;
            wb_en_q     <= wb_en_d;
            bus_err_q   <= bus_err_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign bus_addr    = s_q.alu[31:2];
    assign bus_wdata   = s_q.sdata;
    assign bus_we      = s_q.we;
    assign valid_out   = valid_out_q;
    assign wb_en       = wb_en_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign bus_err     = bus_err_q;
    assign forward     = wb_en_q & valid_out_q;
    assign fwd_rd_addr = wb_rd_q;
    assign fwd_data    = wb_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected retirements are queued at issue
// and compared when valid_out fires; a bus responder models ack latency.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        async_rst = 1'b0;
    logic        clk_en = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] alu_in = '0;
    logic [31:0] store_data = '0;
    logic [31:0] inst_in = '0;
    logic [29:0] pc_in = '0;
    logic [2:0]  wb_lines_in = '0;
    logic        mem_req_in = 1'b0;
    logic        mem_we_in = 1'b0;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_req;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall;
    logic        valid_out;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_err;
    logic        forward;
    logic [4:0]  fwd_rd_addr;
    logic [31:0] fwd_data;

    mem_stage #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .async_rst   (async_rst),
        .clk_en      (clk_en),
        .valid_in    (valid_in),
        .alu_in      (alu_in),
        .store_data  (store_data),
        .inst_in     (inst_in),
        .pc_in       (pc_in),
        .wb_lines_in (wb_lines_in),
        .mem_req_in  (mem_req_in),
        .mem_we_in   (mem_we_in),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_we      (bus_we),
        .bus_req     (bus_req),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .stall       (stall),
        .valid_out   (valid_out),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .bus_err     (bus_err),
        .forward     (forward),
        .fwd_rd_addr (fwd_rd_addr),
        .fwd_data    (fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic        en;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus responder: acks after ack_delay BUSY cycles (-1 = never).
    int          ack_delay = -1;
    logic [31:0] rsp_data = '0;
    logic        ack_noise = 1'b0;
    int          busy_seen = 0;

    always @(posedge clk) begin
        #2;
        if (bus_req) begin
            if (ack_delay >= 0 && busy_seen == ack_delay) begin
                bus_ack   = 1'b1;
                bus_rdata = rsp_data;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 32'h0BAD_0BAD;
            end
            busy_seen++;
        end else begin
            busy_seen = 0;
            bus_ack   = ack_noise;
            bus_rdata = 32'h0BAD_0BAD;
        end
    end

    // Per-cycle observation counters sampled mid-cycle.
    int          stall_cyc = 0;
    int          req_cyc = 0;
    int          req_rise = 0;
    logic        req_prev = 1'b0;
    logic [29:0] cap_addr = '0;
    logic [31:0] cap_wdata = '0;
    logic        cap_we = 1'b0;

    always @(negedge clk) begin
        if (stall) stall_cyc++;
        if (bus_req) begin
            req_cyc++;
            if (!req_prev) req_rise++;
            cap_addr  = bus_addr;
            cap_wdata = bus_wdata;
            cap_we    = bus_we;
        end
        req_prev = bus_req;
    end

    // Retirement monitor.
    logic mon_en;
    exp_t mon_e;
    always @(posedge clk) begin
        mon_en = clk_en & ~async_rst;
        #1;
        if (mon_en && valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
                check("wb_en", {31'd0, wb_en}, {31'd0, mon_e.en});
                check("wb_data", wb_data, mon_e.data);
                check("bus_err", {31'd0, bus_err}, {31'd0, mon_e.err});
                check("forward", {31'd0, forward}, {31'd0, mon_e.en});
                check("fwd_data", fwd_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic clr_cnt();
        stall_cyc = 0;
        req_cyc   = 0;
        req_rise  = 0;
    endtask

    task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [2:0] wb, input logic [29:0] pc, input logic req,
                        input logic we, input logic [31:0] ld, input logic err, input bit push);
        logic [31:0] ins;
        logic [29:0] npc;
        exp_t        e;
        bit          ok;
        ins        = $urandom;
        ins[11:7]  = rd;
        valid_in    = 1'b1;
        alu_in      = alu;
        store_data  = sd;
        inst_in     = ins;
        pc_in       = pc;
        wb_lines_in = wb;
        mem_req_in  = req;
        mem_we_in   = we;
        if (push) begin
            npc    = pc + 30'd1;
            e.rd   = rd;
            e.en   = wb[0] && (rd != 5'd0);
            e.err  = err;
            case (wb[2:1])
                2'b01:   e.data = ld;
                2'b10:   e.data = {npc, 2'b00};
                default: e.data = alu;
            endcase
            sb.push_back(e);
        end
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (clk_en && !stall) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        step();
        valid_in = 1'b0;
    endtask

    initial begin
        #1 async_rst = 1'b1;
        step();
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_valid_out", {31'd0, valid_out}, 32'd0);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_forward", {31'd0, forward}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        async_rst = 1'b0;
        idle(2);

        // Plain ALU op: single-cycle, no stall.
        clr_cnt();
        send(32'd6, 32'd0, 5'd3, 3'b001, 30'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(3);
        check("alu_stall", stall_cyc, 32'd0);

        // Load with ack on the fourth BUSY cycle (last one before timeout).
        ack_delay = 3;
        rsp_data  = 32'hDEAD_BEEF;
        clr_cnt();
        send(32'h100, 32'd0, 5'd5, 3'b011, 30'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle(8);
        check("ld_stall_cycles", stall_cyc, 32'd4);
        check("ld_bus_addr", {2'd0, cap_addr}, 32'h40);
        check("ld_bus_we", {31'd0, cap_we}, 32'd0);

        // Store to rd=0: bus write, no register write-back.
        ack_delay = 0;
        send(32'h20, 32'h55, 5'd0, 3'b001, 30'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        idle(5);
        check("st_bus_we", {31'd0, cap_we}, 32'd1);
        check("st_bus_addr", {2'd0, cap_addr}, 32'h8);
        check("st_bus_wdata", cap_wdata, 32'h55);

        // Back-to-back loads with immediate ack: an IDLE cycle separates them.
        rsp_data = 32'h1234_5678;
        clr_cnt();
        send(32'h200, 32'd0, 5'd10, 3'b011, 30'd0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        send(32'h204, 32'd0, 5'd11, 3'b011, 30'd0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        idle(6);
        check("b2b_req_rise", req_rise, 32'd2);
        check("b2b_req_cycles", req_cyc, 32'd2);
        check("b2b_stall_cycles", stall_cyc, 32'd2);

        // Ack arrives while the pipeline is frozen; retires from the load buffer later.
        ack_delay = 1;
        rsp_data  = 32'hCAFE_0001;
        send(32'h300, 32'd0, 5'd9, 3'b011, 30'd0, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b1);
        clk_en = 1'b0;
        repeat (4) step();
        ack_noise = 1'b1;
        step();
        check("frz_bus_req", {31'd0, bus_req}, 32'd0);
        check("frz_stall", {31'd0, stall}, 32'd0);
        check("frz_valid_out", {31'd0, valid_out}, 32'd0);
        step();
        ack_noise = 1'b0;
        step();
        clk_en = 1'b1;
        idle(4);

        // No ack at all: abort after TIMEOUT BUSY cycles, then a clean ALU op.
        ack_delay = -1;
        clr_cnt();
        send(32'h400, 32'd0, 5'd7, 3'b011, 30'd0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        idle(8);
        check("to_req_cycles", req_cyc, 32'd4);
        send(32'hABC, 32'd0, 5'd8, 3'b001, 30'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(3);

        // Reset in the middle of a transaction: nothing retires, late ack ignored.
        send(32'h500, 32'd0, 5'd12, 3'b011, 30'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        step();
        step();
        check("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
        async_rst = 1'b1;
        #1;
        check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        step();
        async_rst = 1'b0;
        ack_noise = 1'b1;
        clr_cnt();
        idle(3);
        ack_noise = 1'b0;
        check("post_rst_req_cycles", req_cyc, 32'd0);

        // Link ops, including 30-bit PC wrap.
        send(32'h0, 32'd0, 5'd1, 3'b101, 30'h10, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        send(32'h0, 32'd0, 5'd2, 3'b101, 30'h3FFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        send(32'h77, 32'd0, 5'd4, 3'b111, 30'h20, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
        idle(3);

        for (int n = 0; n < 50 && sb.size() != 0; n++) step();
        check("sb_drain", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
